// File: rtl/ika87ad_mc_pkg.sv
// ika87ad_mc_pkg: shared microcode definitions for the IKA87AD sequencer.
package ika87ad_mc_pkg;

    localparam logic [1:0] RD3      = 2'd0;
    localparam logic [1:0] RD4      = 2'd1;
    localparam logic [1:0] WR3      = 2'd2;
    localparam logic [1:0] BUS_RSVD = 2'd3;

    localparam logic [1:0] MCTYPE0 = 2'd0;
    localparam logic [1:0] MCTYPE1 = 2'd1;
    localparam logic [1:0] MCTYPE2 = 2'd2;
    localparam logic [1:0] MCTYPE3 = 2'd3;

    localparam int MC_TYPE_HI  = 17;
    localparam int MC_TYPE_LO  = 16;
    localparam int MC_NOP_HI   = 13;
    localparam int MC_NOP_LO   = 9;
    localparam int MC_IDLE_BIT = 9;
    localparam int MC_BUS_HI   = 1;
    localparam int MC_BUS_LO   = 0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        NOPW,
        BUS
    } mcseq_state_e;

    // The reserved bus code runs as a plain 3-state read.
    function automatic logic [1:0] bus_decode(input logic [1:0] code);
        return (code == BUS_RSVD) ? RD3 : code;
    endfunction

    function automatic logic [1:0] bus_limit(input logic [1:0] code);
        return (code == RD4) ? 2'd3 : 2'd2;
    endfunction

endpackage

// File: rtl/ika87ad_mcseq_tcnt.sv
// ika87ad_mcseq_tcnt: T-state counter; restarts at T1 on i_START, flags the limit state.
module ika87ad_mcseq_tcnt (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_CEN,
    input  logic       i_START,
    input  logic [1:0] i_LIMIT,
    output logic [1:0] o_TSTATE,
    output logic       o_LAST
);

    logic [1:0] tstate_q, tstate_d;

    assign tstate_d = i_START ? 2'd0 : tstate_q + 2'd1;
    assign o_TSTATE = tstate_q;
    assign o_LAST   = (tstate_q == i_LIMIT);

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST)
            tstate_q <= 2'd0;
        else if (i_CEN)
            tstate_q <= tstate_d;
    end

endmodule

// File: rtl/ika87ad_mcseq.sv
// ika87ad_mcseq: microcode sequencer; steps the ROM address, latches microwords
// and runs the bus cycle each microword requests, ending the instruction on RD4.
module ika87ad_mcseq
    import ika87ad_mc_pkg::*;
(
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_CEN,
    input  logic        i_START,
    input  logic [7:0]  i_START_ADDR,
    output logic        o_READY,
    output logic        o_MCROM_READ_TICK,
    output logic [7:0]  o_MCROM_ADDR,
    input  logic [17:0] i_MCROM_DATA,
    output logic [17:0] o_MC,
    output logic        o_MC_EXEC,
    output logic [1:0]  o_BUS_CODE,
    output logic        o_BUS_START,
    output logic [1:0]  o_TSTATE,
    output logic        o_INSTR_DONE
);

    mcseq_state_e state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [17:0] mc_q, mc_d;
    logic [1:0]  bus_code_q, bus_code_d;
    logic [1:0]  tstate;
    logic        tc_last, tc_start, bus_end, is_rd4, extra_idle;

    assign is_rd4     = (bus_code_q == RD4);
    assign bus_end    = (state_q == BUS) && tc_last;
    assign tc_start   = (state_q != BUS) || tc_last;
    assign extra_idle = (i_MCROM_DATA[MC_TYPE_HI:MC_TYPE_LO] == MCTYPE3) && i_MCROM_DATA[MC_IDLE_BIT];

    ika87ad_mcseq_tcnt u_tcnt (
        .i_CLK    (i_CLK),
        .i_RST    (i_RST),
        .i_CEN    (i_CEN),
        .i_START  (tc_start),
        .i_LIMIT  (bus_limit(bus_code_q)),
        .o_TSTATE (tstate),
        .o_LAST   (tc_last)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mc_d       = mc_q;
        bus_code_d = bus_code_q;
        case (state_q)
            IDLE: begin
                if (i_START) begin
                    state_d = FETCH;
                    addr_d  = i_START_ADDR;
                end
            end
            FETCH: state_d = EXEC;
            EXEC: begin
                mc_d       = i_MCROM_DATA;
                bus_code_d = bus_decode(i_MCROM_DATA[MC_BUS_HI:MC_BUS_LO]);
                state_d    = extra_idle ? NOPW : BUS;
            end
            NOPW: state_d = BUS;
            BUS: begin
                // RD4 ends the instruction; a held START chains the next one with no bubble.
                if (tc_last && !is_rd4) begin
                    state_d = FETCH;
                    addr_d  = addr_q + 8'd1;
                end else if (tc_last && i_START) begin
                    state_d = FETCH;
                    addr_d  = i_START_ADDR;
                end else if (tc_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q    <= IDLE;
            addr_q     <= 8'd0;
            mc_q       <= 18'd0;
            bus_code_q <= RD4;
        end else if (i_CEN) begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mc_q       <= mc_d;
            bus_code_q <= bus_code_d;
        end
    end

    assign o_MCROM_ADDR      = addr_q;
    assign o_MC              = mc_q;
    assign o_BUS_CODE        = bus_code_q;
    assign o_TSTATE          = tstate;
    assign o_MCROM_READ_TICK = i_CEN && (state_q == FETCH);
    assign o_MC_EXEC         = i_CEN && (state_q == EXEC);
    assign o_BUS_START       = i_CEN && (state_q == BUS) && (tstate == 2'd0);
    assign o_INSTR_DONE      = i_CEN && bus_end && is_rd4;
    assign o_READY           = (state_q == IDLE) || o_INSTR_DONE;

endmodule

// File: tb/tb_ika87ad_mcseq.sv
// tb_ika87ad_mcseq: scoreboard bench; a spec-level timing model queues the expected
// strobes and a per-cycle monitor pops and compares them as the DUT fires.
module tb_ika87ad_mcseq;

    logic        clk = 1'b0;
    logic        rst, cen, start;
    logic [7:0]  saddr;
    logic        ready, tick, exec, bstart, done;
    logic [7:0]  addr;
    logic [17:0] rom_q, mc;
    logic [1:0]  bcode, tstate;

    ika87ad_mcseq dut (
        .i_CLK             (clk),
        .i_RST             (rst),
        .i_CEN             (cen),
        .i_START           (start),
        .i_START_ADDR      (saddr),
        .o_READY           (ready),
        .o_MCROM_READ_TICK (tick),
        .o_MCROM_ADDR      (addr),
        .i_MCROM_DATA      (rom_q),
        .o_MC              (mc),
        .o_MC_EXEC         (exec),
        .o_BUS_CODE        (bcode),
        .o_BUS_START       (bstart),
        .o_TSTATE          (tstate),
        .o_INSTR_DONE      (done)
    );

    always #5 clk = ~clk;

    logic [17:0] rom [256];
    always @(posedge clk) if (tick) rom_q <= rom[addr];

    typedef struct {
        int          kind;
        int          cyc;
        logic [17:0] val;
        logic [1:0]  code;
    } ev_t;

    ev_t q[$];
    int  n_pass = 0, n_tot = 0, cyc = 0;
    localparam int NO_FREEZE = 1 << 30;

    logic [34:0] outs;
    assign outs = {ready, tick, exec, bstart, done, addr, mc, bcode, tstate};
    localparam logic [34:0] RESET_OUTS = {5'b10000, 8'h00, 18'h0, 2'd1, 2'd0};

    function automatic logic [17:0] mw(input logic [1:0] ty, input logic [4:0] nop, input logic [1:0] bc);
        return {ty, 2'b00, nop, 7'b0, bc};
    endfunction

    task automatic add(input int kind, input int c, input logic [17:0] v, input logic [1:0] code,
                       input int fc, input int fl);
        ev_t e;
        e.kind = kind;
        e.cyc  = (c >= fc) ? c + fl : c;
        e.val  = v;
        e.code = code;
        q.push_back(e);
    endtask

    // kinds: 0 tick, 1 exec, 2 bus start, 3 instr done; events from cycle fc on are delayed by fl
    task automatic push_instr(input int t0, input logic [7:0] a0, input int fc, input int fl);
        logic [7:0]  a;
        logic [17:0] w;
        logic [1:0]  code;
        int          t;
        bit          fin;
        a = a0;
        t = t0 + 1;
        fin = 0;
        for (int g = 0; g < 8 && !fin; g++) begin
            w    = rom[a];
            code = (w[1:0] == 2'd3) ? 2'd0 : w[1:0];
            add(0, t, {10'b0, a}, 2'd0, fc, fl);
            add(1, t + 1, w, 2'd0, fc, fl);
            t = t + 2 + ((w[17:16] == 2'd3 && w[9]) ? 1 : 0);
            add(2, t, w, code, fc, fl);
            if (code == 2'd1) begin
                add(3, t + 3, w, code, fc, fl);
                fin = 1;
            end else begin
                a = a + 8'd1;
                t = t + 3;
            end
        end
    endtask

    task automatic monitor();
        logic [3:0] seen;
        ev_t        e;
        bit         ok;
        cyc++;
        seen = {done, bstart, exec, tick};
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            n_tot++;
            $display("FAIL missing_ev kind=%0d never seen, required at cycle %0d (now %0d)", e.kind, e.cyc, cyc);
        end
        for (int k = 0; k < 4; k++) begin
            if (seen[k]) begin
                n_tot++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_ev kind=%0d at cycle %0d, none required", k, cyc);
                end else begin
                    e  = q.pop_front();
                    ok = (e.kind == k) && (e.cyc == cyc);
                    if (k == 0) ok = ok && (addr === e.val[7:0]);
                    if (k == 2) ok = ok && (mc === e.val) && (bcode === e.code) && (tstate === 2'd0);
                    if (k == 3) ok = ok && (ready === 1'b1) && (tstate === 2'd3);
                    if (ok) n_pass++;
                    else $display("FAIL ev got kind=%0d cyc=%0d addr=%h mc=%h code=%0d ts=%0d rdy=%b, required kind=%0d cyc=%0d val=%h code=%0d",
                                  k, cyc, addr, mc, bcode, tstate, ready, e.kind, e.cyc, e.val, e.code);
                end
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            monitor();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cen = 1'b1;
        start = 1'b0;
        saddr = 8'h00;
        #3;
        n_tot++;
        if (outs !== RESET_OUTS) $display("FAIL reset_outs got %h required %h", outs, RESET_OUTS);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(2);
        n_tot++;
        if (outs !== RESET_OUTS) $display("FAIL idle_outs got %h required %h", outs, RESET_OUTS);
        else n_pass++;
    endtask

    task automatic launch(input logic [7:0] a, input int fc, input int fl);
        saddr = a;
        start = 1'b1;
        push_instr(cyc + 1, a, fc, fl);
        run(1);
        start = 1'b0;
    endtask

    task automatic check_drained(input string name);
        n_tot++;
        if (q.size() != 0) $display("FAIL %s_drained got %0d pending events required 0", name, q.size());
        else n_pass++;
    endtask

    task automatic test_nop();
        rom[8'h10] = mw(2'd3, 5'b00000, 2'd1);
        launch(8'h10, NO_FREEZE, 0);
        run(8);
        check_drained("nop");
        n_tot++;
        if (ready !== 1'b1) $display("FAIL nop_ready_after got %b required 1", ready);
        else n_pass++;
    endtask

    task automatic test_two_step();
        rom[8'h20] = mw(2'd0, 5'b00000, 2'd0);
        rom[8'h21] = mw(2'd1, 5'b00110, 2'd1);
        launch(8'h20, NO_FREEZE, 0);
        run(13);
        check_drained("two_step");
    endtask

    task automatic test_extra_idle();
        rom[8'h30] = mw(2'd3, 5'b10001, 2'd0);
        rom[8'h31] = mw(2'd3, 5'b00000, 2'd1);
        launch(8'h30, NO_FREEZE, 0);
        run(14);
        check_drained("extra_idle");
    endtask

    task automatic test_wrap();
        rom[8'hFF] = mw(2'd0, 5'b00010, 2'd0);
        rom[8'h00] = mw(2'd1, 5'b00000, 2'd1);
        launch(8'hFF, NO_FREEZE, 0);
        run(13);
        check_drained("wrap");
    endtask

    task automatic test_freeze();
        int t0;
        rom[8'h40] = mw(2'd1, 5'b00100, 2'd2);
        rom[8'h41] = mw(2'd1, 5'b00000, 2'd1);
        t0 = cyc + 1;
        launch(8'h40, t0 + 4, 5);
        run(3);
        cen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run(1);
            n_tot++;
            if (tstate !== 2'd1 || {tick, exec, bstart, done} !== 4'b0)
                $display("FAIL freeze_%0d got ts=%0d strobes=%b required ts=1 strobes=0000", i, tstate, {tick, exec, bstart, done});
            else n_pass++;
        end
        cen = 1'b1;
        run(10);
        check_drained("freeze");
    endtask

    task automatic test_reset_mid();
        rom[8'h50] = mw(2'd1, 5'b00000, 2'd1);
        rom[8'h60] = mw(2'd3, 5'b00000, 2'd1);
        launch(8'h50, NO_FREEZE, 0);
        run(3);
        n_tot++;
        if (tstate !== 2'd1) $display("FAIL mid_pre_ts got %0d required 1", tstate);
        else n_pass++;
        q.delete();
        #2;
        rst = 1'b1;
        #1;
        n_tot++;
        if (outs !== RESET_OUTS) $display("FAIL mid_reset_outs got %h required %h", outs, RESET_OUTS);
        else n_pass++;
        run(2);
        rst = 1'b0;
        run(2);
        launch(8'h60, NO_FREEZE, 0);
        run(8);
        check_drained("after_reset");
    endtask

    task automatic test_back_to_back();
        int t0;
        rom[8'h70] = mw(2'd3, 5'b00000, 2'd1);
        rom[8'h80] = mw(2'd2, 5'b00001, 2'd3);
        rom[8'h81] = mw(2'd1, 5'b00000, 2'd1);
        t0 = cyc + 1;
        saddr = 8'h70;
        start = 1'b1;
        push_instr(t0, 8'h70, NO_FREEZE, 0);
        push_instr(t0 + 6, 8'h80, NO_FREEZE, 0);
        run(1);
        saddr = 8'h80;
        run(6);
        start = 1'b0;
        run(13);
        check_drained("b2b");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 18'h0;
        rom_q = 18'h0;
        test_reset();
        test_nop();
        test_two_step();
        test_extra_idle();
        test_wrap();
        test_freeze();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
